reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 33 +++
 rtl/reg_bank_irq.sv | 43 ++++
 rtl/reg_bank.sv | 123 ++++++++++++
 tb/tb_reg_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and address-decode helpers for the reg_bank register file.
package reg_bank_pkg;

    // Offsets of the interrupt registers, counted from the end of the RO window.
    localparam int unsigned IRQ_STAT_OFS = 0;
    localparam int unsigned IRQ_EN_OFS   = 1;

    typedef enum logic [2:0] {
        REG_GP,
        REG_RO,
        REG_IRQ_STAT,
        REG_IRQ_EN,
        REG_UNMAPPED
    } region_e;

    function automatic region_e decode_region(input int unsigned addr,
                                              input int unsigned gp_num,
                                              input int unsigned ro_num);
        region_e r;
        if (addr < gp_num)
            r = REG_GP;
        else if (addr < gp_num + ro_num)
            r = REG_RO;
        else if (addr == gp_num + ro_num + IRQ_STAT_OFS)
            r = REG_IRQ_STAT;
        else if (addr == gp_num + ro_num + IRQ_EN_OFS)
            r = REG_IRQ_EN;
        else
            r = REG_UNMAPPED;
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_irq.sv
// Interrupt block: rising-edge detect, sticky W1C status, enable mask, pending OR.
module reg_bank_irq #(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_in,
    input  logic             stat_w1c,
    input  logic             en_we,
    input  logic [IRQ_W-1:0] wdata,
    output logic [IRQ_W-1:0] irq_stat,
    output logic [IRQ_W-1:0] irq_en,
    output logic             irq_pending
);

    logic [IRQ_W-1:0] irq_prev;
    logic             armed;
    logic [IRQ_W-1:0] rise;
    logic [IRQ_W-1:0] clr;

    // The first edge after reset only loads history, so lines already high
    // at release do not count as a rising edge.
    assign rise = armed ? (irq_in & ~irq_prev) : '0;
    assign clr  = stat_w1c ? wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            armed    <= 1'b0;
            irq_stat <= '0;
            irq_en   <= '0;
        end else begin
            armed    <= 1'b1;
            irq_prev <= irq_in;
            irq_stat <= (irq_stat & ~clr) | rise;
            if (en_we)
                irq_en <= wdata;
        end
    end

    assign irq_pending = |(irq_stat & irq_en);

endmodule

// File: rtl/reg_bank.sv
// Register bank: GP r/w registers, read-only window, IRQ status/enable, two read ports.
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int              DATA_W      = 8,
    parameter int              ADDR_W      = 6,
    parameter int              GP_NUM      = 32,
    parameter int              RO_NUM      = 8,
    parameter int              IRQ_W       = 8,
    parameter logic [GP_NUM-1:0] STROBE_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_enable,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [ADDR_W-1:0]        r_addr_a,
    input  logic [ADDR_W-1:0]        r_addr_b,
    output logic [DATA_W-1:0]        r_data_a,
    output logic [DATA_W-1:0]        r_data_b,
    output logic [GP_NUM*DATA_W-1:0] gp_flat,
    input  logic [RO_NUM*DATA_W-1:0] ro_data,
    input  logic [IRQ_W-1:0]         irq_in,
    output logic                     irq_pending,
    output logic                     write_err
);

    if (GP_NUM + RO_NUM + 2 > 2**ADDR_W) begin : g_bad_map
        $error("reg_bank: address map does not fit in ADDR_W bits");
    end
    if (IRQ_W > DATA_W) begin : g_bad_irq
        $error("reg_bank: IRQ_W must not exceed DATA_W");
    end

    // Write port: a write is taken on any rising clk edge with w_enable=1.
    region_e                        w_region;
    logic                           w_gp;
    logic [GP_NUM-1:0][DATA_W-1:0]  gp_q;
    logic [IRQ_W-1:0]               irq_stat;
    logic [IRQ_W-1:0]               irq_en;

    assign w_region = decode_region(32'(w_addr), GP_NUM, RO_NUM);
    assign w_gp     = w_enable && (w_region == REG_GP);
    assign gp_flat  = gp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gp_q <= '0;
        end else begin
            for (int i = 0; i < GP_NUM; i++) begin
                if (w_gp && (w_addr == ADDR_W'(i)))
                    gp_q[i] <= w_data;
                else if (STROBE_MASK[i])
                    gp_q[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            write_err <= 1'b0;
        else
            write_err <= w_enable && ((w_region == REG_RO) || (w_region == REG_UNMAPPED));
    end

    reg_bank_irq #(.IRQ_W(IRQ_W)) u_irq (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .stat_w1c    (w_enable && (w_region == REG_IRQ_STAT)),
        .en_we       (w_enable && (w_region == REG_IRQ_EN)),
        .wdata       (w_data[IRQ_W-1:0]),
        .irq_stat    (irq_stat),
        .irq_en      (irq_en),
        .irq_pending (irq_pending)
    );

    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_data [2];

    assign r_addr[0] = r_addr_a;
    assign r_addr[1] = r_addr_b;
    assign r_data_a  = r_data[0];
    assign r_data_b  = r_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        region_e           r_region;
        logic [DATA_W-1:0] rd;

        always_comb begin
            rd       = '0;
            r_region = decode_region(32'(r_addr[p]), GP_NUM, RO_NUM);
            case (r_region)
                REG_GP: begin
                    for (int i = 0; i < GP_NUM; i++)
                        if (r_addr[p] == ADDR_W'(i))
                            rd = gp_q[i];
                end
                REG_RO: begin
                    for (int j = 0; j < RO_NUM; j++)
                        if (r_addr[p] == ADDR_W'(GP_NUM + j))
                            rd = ro_data[j*DATA_W +: DATA_W];
                end
                REG_IRQ_STAT: rd = DATA_W'(irq_stat);
                REG_IRQ_EN:   rd = DATA_W'(irq_en);
                default:      rd = '0;
            endcase
`ifdef REG_BANK_BYPASS_EN
            // Status is W1C, so forwarding w_data there would be meaningless.
            if (w_enable && (w_addr == r_addr[p])) begin
                if (w_region == REG_GP)
                    rd = w_data;
                else if (w_region == REG_IRQ_EN)
                    rd = DATA_W'(w_data[IRQ_W-1:0]);
            end
`endif
        end

        assign r_data[p] = rd;
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed table-driven bench for reg_bank (GP=32, RO=8, STAT=40, EN=41, strobe on reg 4).
module tb_reg_bank;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         w_enable = 1'b0;
    logic [5:0]   w_addr = '0;
    logic [7:0]   w_data = '0;
    logic [5:0]   r_addr_a = '0;
    logic [5:0]   r_addr_b = '0;
    logic [7:0]   r_data_a;
    logic [7:0]   r_data_b;
    logic [255:0] gp_flat;
    logic [63:0]  ro_data;
    logic [7:0]   irq_in = '0;
    logic         irq_pending;
    logic         write_err;

    int n_vec = 0;
    int n_err = 0;

    reg_bank #(
        .DATA_W(8), .ADDR_W(6), .GP_NUM(32), .RO_NUM(8), .IRQ_W(8),
        .STROBE_MASK(32'h0000_0010)
    ) dut (
        .clk(clk), .rst(rst),
        .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
        .r_data_a(r_data_a), .r_data_b(r_data_b),
        .gp_flat(gp_flat), .ro_data(ro_data),
        .irq_in(irq_in), .irq_pending(irq_pending), .write_err(write_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         we;
        logic [5:0] wa;
        logic [7:0] wd;
        logic [5:0] ra;
        logic [5:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        bit         eerr;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cyc(input bit we, input logic [5:0] wa, input logic [7:0] wd,
                       input logic [5:0] ra, input logic [5:0] rb);
        @(negedge clk);
        w_enable = we;
        w_addr   = wa;
        w_data   = wd;
        r_addr_a = ra;
        r_addr_b = rb;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit we, logic [5:0] wa, logic [7:0] wd, logic [5:0] ra,
                                logic [5:0] rb, logic [7:0] ea, logic [7:0] eb, bit eerr);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.ea = ea; v.eb = eb; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        for (int j = 0; j < 8; j++)
            ro_data[j*8 +: 8] = 8'hA0 + 8'(j);

        vecs[0]  = mk(0, 0,  8'h00, 3,  3,  8'h00, 8'h00, 0);
        vecs[1]  = mk(1, 3,  8'h5A, 2,  0,  8'h00, 8'h00, 0);
        vecs[2]  = mk(0, 0,  8'h00, 3,  3,  8'h5A, 8'h5A, 0);
        vecs[3]  = mk(1, 32, 8'hFF, 32, 33, 8'hA0, 8'hA1, 1);
        vecs[4]  = mk(0, 0,  8'h00, 32, 3,  8'hA0, 8'h5A, 0);
        vecs[5]  = mk(1, 63, 8'h11, 63, 3,  8'h00, 8'h5A, 1);
        vecs[6]  = mk(0, 0,  8'h00, 63, 63, 8'h00, 8'h00, 0);
        vecs[7]  = mk(1, 4,  8'h01, 5,  32, 8'h00, 8'hA0, 0);
        vecs[8]  = mk(0, 0,  8'h00, 4,  4,  8'h01, 8'h01, 0);
        vecs[9]  = mk(0, 0,  8'h00, 4,  4,  8'h00, 8'h00, 0);
        vecs[10] = mk(1, 41, 8'h04, 40, 3,  8'h00, 8'h5A, 0);
        vecs[11] = mk(1, 10, 8'hC3, 41, 40, 8'h04, 8'h00, 0);
        vecs[12] = mk(1, 45, 8'h99, 10, 41, 8'hC3, 8'h04, 1);
        vecs[13] = mk(1, 31, 8'h3C, 30, 33, 8'h00, 8'hA1, 0);
        vecs[14] = mk(0, 0,  8'h00, 31, 39, 8'h3C, 8'hA7, 0);

        // Asynchronous reset state, before any clock edge has been seen.
        #2;
        check("reset_rda", 32'(r_data_a), 32'h00);
        check("reset_gp_flat_zero", 32'(gp_flat == '0), 32'h1);
        check("reset_pending", 32'(irq_pending), 32'h0);
        check("reset_write_err", 32'(write_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
            check($sformatf("vec%0d_rd_a", i), 32'(r_data_a), 32'(vecs[i].ea));
            check($sformatf("vec%0d_rd_b", i), 32'(r_data_b), 32'(vecs[i].eb));
            post_edge();
            check($sformatf("vec%0d_write_err", i), 32'(write_err), 32'(vecs[i].eerr));
            if (i == 2)
                check("gp_flat_reg3", 32'(gp_flat[31:24]), 32'h5A);
        end

        // Window reads follow ro_data combinationally.
        ro_data[7:0] = 8'h5C;
        cyc(0, 0, 8'h00, 32, 39);
        check("ro_track_a", 32'(r_data_a), 32'h5C);
        check("ro_track_b", 32'(r_data_b), 32'hA7);

        // Strobe register rewritten in its visible cycle keeps the new value one more cycle.
        cyc(1, 4, 8'h02, 0, 0);
        post_edge();
        check("strobe_w1", 32'(gp_flat[39:32]), 32'h02);
        cyc(1, 4, 8'h03, 0, 0);
        post_edge();
        check("strobe_rewrite", 32'(gp_flat[39:32]), 32'h03);
        cyc(0, 0, 8'h00, 0, 0);
        post_edge();
        check("strobe_clear", 32'(gp_flat[39:32]), 32'h00);

        // IRQ: edge on bit 2 with IRQ_EN=0x04.
        cyc(0, 0, 8'h00, 40, 41);
        irq_in = 8'h04;
        #1;
        check("irq_before_edge", 32'(r_data_a), 32'h00);
        check("pending_before_edge", 32'(irq_pending), 32'h0);
        post_edge();
        check("pending_after_edge", 32'(irq_pending), 32'h1);
        cyc(1, 40, 8'h04, 40, 41);
        check("stat_not_bypassed", 32'(r_data_a), 32'h04);
        post_edge();
        check("pending_after_w1c", 32'(irq_pending), 32'h0);
        cyc(0, 0, 8'h00, 40, 41);
        check("stat_after_w1c", 32'(r_data_a), 32'h00);
        irq_in = 8'h00;
        cyc(0, 0, 8'h00, 40, 41);
        irq_in = 8'h04;
        post_edge();
        check("pending_reedge", 32'(irq_pending), 32'h1);
        cyc(1, 40, 8'h00, 40, 41);
        post_edge();
        cyc(0, 0, 8'h00, 40, 41);
        check("stat_write0_keeps", 32'(r_data_a), 32'h04);
        irq_in = 8'h00;
        cyc(1, 40, 8'h04, 40, 41);
        irq_in = 8'h04;
        post_edge();
        cyc(0, 0, 8'h00, 40, 41);
        check("stat_set_beats_w1c", 32'(r_data_a), 32'h04);
        check("pending_set_beats_w1c", 32'(irq_pending), 32'h1);

        // Same-cycle read of a register being written.
        cyc(1, 5, 8'h77, 5, 5);
`ifdef REG_BANK_BYPASS_EN
        check("bypass_gp_a", 32'(r_data_a), 32'h77);
        check("bypass_gp_b", 32'(r_data_b), 32'h77);
`else
        check("nobypass_gp_a", 32'(r_data_a), 32'h00);
        check("nobypass_gp_b", 32'(r_data_b), 32'h00);
`endif
        cyc(1, 41, 8'h0C, 41, 40);
`ifdef REG_BANK_BYPASS_EN
        check("bypass_en", 32'(r_data_a), 32'h0C);
`else
        check("nobypass_en", 32'(r_data_a), 32'h04);
`endif
        check("stat_during_en_write", 32'(r_data_b), 32'h04);
        cyc(0, 0, 8'h00, 5, 41);
        check("gp5_after_write", 32'(r_data_a), 32'h77);
        check("en_after_write", 32'(r_data_b), 32'h0C);

        // Mid-cycle asynchronous reset with nonzero state and write_err high.
        cyc(1, 63, 8'h00, 3, 40);
        post_edge();
        check("err_before_reset", 32'(write_err), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_gp_flat_zero", 32'(gp_flat == '0), 32'h1);
        check("rst_rd_gp3", 32'(r_data_a), 32'h00);
        check("rst_rd_stat", 32'(r_data_b), 32'h00);
        check("rst_pending", 32'(irq_pending), 32'h0);
        check("rst_write_err", 32'(write_err), 32'h0);
        cyc(1, 3, 8'h99, 3, 40);
        post_edge();
        @(negedge clk);
        rst      = 1'b0;
        w_enable = 1'b1;
        w_addr   = 6;
        w_data   = 8'h12;
        post_edge();
        cyc(0, 0, 8'h00, 6, 3);
        check("first_write_after_release", 32'(r_data_a), 32'h12);
        check("write_during_rst_ignored", 32'(r_data_b), 32'h00);
        cyc(0, 0, 8'h00, 40, 41);
        cyc(0, 0, 8'h00, 40, 41);
        check("held_irq_no_stat", 32'(r_data_a), 32'h00);
        irq_in = 8'h00;
        cyc(0, 0, 8'h00, 40, 41);
        irq_in = 8'h04;
        post_edge();
        cyc(0, 0, 8'h00, 40, 41);
        check("irq_after_reraise", 32'(r_data_a), 32'h04);
        check("pending_en_cleared", 32'(irq_pending), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
